// File: rtl/sram_pkg.sv
// Shared types and widths for the audio SRAM arbiter.
// The state and grant encodings live here so the TB and RTL agree on widths.
package sram_pkg;

  localparam int ADDR_W = 18;
  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    W_SETUP,
    W_PULSE,
    W_HOLD,
    R_ADDR,
    R_SAMPLE
  } sram_state_t;

  typedef enum logic {
    WRITE,
    READ
  } grant_t;

endpackage

// File: rtl/sram_arbiter.sv
// Round-robin arbiter between ADC writes and DAC reads on one async SRAM.
// Owns all SRAM pins; every strobe and the bus enable come from flops.
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int ADDR_W  = sram_pkg::ADDR_W,
  parameter int DATA_W  = sram_pkg::DATA_W,
  parameter int WR_WAIT = 1,
  parameter int RD_WAIT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_ack,
  output logic              busy,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_dq,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_lb_n,
  output logic              sram_ub_n
);

  localparam int MAX_WAIT = (WR_WAIT > RD_WAIT) ? WR_WAIT : RD_WAIT;
  localparam int CNT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WR_LD = CNT_W'(WR_WAIT - 1);
  localparam logic [CNT_W-1:0] RD_LD = CNT_W'(RD_WAIT - 1);

  sram_state_t       state;
  grant_t            last_grant;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] wdat;
  logic              dq_oe;

  logic grant_wr;
  assign grant_wr = wr_req && (!rd_req || last_grant == READ);

  assign sram_dq = dq_oe ? wdat : 'z;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= READ;
      cnt        <= '0;
      wdat       <= '0;
      dq_oe      <= 1'b0;
      sram_addr  <= '0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_lb_n  <= 1'b1;
      sram_ub_n  <= 1'b1;
      wr_ack     <= 1'b0;
      rd_ack     <= 1'b0;
      rd_data    <= '0;
      busy       <= 1'b0;
    end else begin
      wr_ack <= 1'b0;
      rd_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_wr) begin
            state      <= W_SETUP;
            last_grant <= WRITE;
            sram_addr  <= wr_addr;
            wdat       <= wr_data;
            dq_oe      <= 1'b1;
            sram_ce_n  <= 1'b0;
            sram_lb_n  <= 1'b0;
            sram_ub_n  <= 1'b0;
            busy       <= 1'b1;
          end else if (rd_req) begin
            state      <= R_ADDR;
            last_grant <= READ;
            sram_addr  <= rd_addr;
            cnt        <= RD_LD;
            sram_ce_n  <= 1'b0;
            sram_oe_n  <= 1'b0;
            sram_lb_n  <= 1'b0;
            sram_ub_n  <= 1'b0;
            busy       <= 1'b1;
          end
        end
        W_SETUP: begin
          state     <= W_PULSE;
          sram_we_n <= 1'b0;
          cnt       <= WR_LD;
        end
        W_PULSE: begin
          if (cnt == '0) begin
            state     <= W_HOLD;
            sram_we_n <= 1'b1;
            wr_ack    <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        W_HOLD: begin
          // data held one cycle past the we_n rising edge
          state     <= IDLE;
          dq_oe     <= 1'b0;
          sram_ce_n <= 1'b1;
          sram_lb_n <= 1'b1;
          sram_ub_n <= 1'b1;
          busy      <= 1'b0;
        end
        R_ADDR: begin
          if (cnt == '0) begin
            state     <= R_SAMPLE;
            rd_data   <= sram_dq;
            rd_ack    <= 1'b1;
            sram_oe_n <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        R_SAMPLE: begin
          state     <= IDLE;
          sram_ce_n <= 1'b1;
          sram_lb_n <= 1'b1;
          sram_ub_n <= 1'b1;
          busy      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter with a behavioural SRAM and
// a round-robin order model; a negedge monitor checks pins and acks.
module tb_sram_arbiter;

  localparam int WR_WAIT = 1;
  localparam int RD_WAIT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_req = 1'b0;
  logic [17:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        wr_ack;
  logic        rd_req = 1'b0;
  logic [17:0] rd_addr = '0;
  logic [15:0] rd_data;
  logic        rd_ack;
  logic        busy;
  logic [17:0] sram_addr;
  wire  [15:0] sram_dq;
  logic        sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;

  sram_arbiter #(
    .WR_WAIT(WR_WAIT),
    .RD_WAIT(RD_WAIT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .wr_req(wr_req),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .wr_ack(wr_ack),
    .rd_req(rd_req),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .rd_ack(rd_ack),
    .busy(busy),
    .sram_addr(sram_addr),
    .sram_dq(sram_dq),
    .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n),
    .sram_lb_n(sram_lb_n),
    .sram_ub_n(sram_ub_n)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] dflt(input logic [17:0] a);
    return a[15:0] ^ 16'h5A5A;
  endfunction

  // behavioural SRAM
  logic [15:0] sram_mem [int];
  logic [15:0] drv = '0;
  logic        drv_en = 1'b0;
  assign sram_dq = drv_en ? drv : 'z;

  always @(negedge clk) begin
    if (!sram_ce_n && !sram_we_n)
      sram_mem[int'(sram_addr)] = sram_dq;
    drv_en = !sram_ce_n && !sram_oe_n;
    drv = sram_mem.exists(int'(sram_addr)) ? sram_mem[int'(sram_addr)] : dflt(sram_addr);
  end

  // reference model: memory contents and expected completion order
  typedef struct {
    bit          rd;
    logic [17:0] a;
    logic [15:0] d;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] ref_mem [int];
  bit          last_rd = 1'b1;

  function automatic logic [15:0] ref_rd(input logic [17:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : dflt(a);
  endfunction

  // monitor
  exp_t        me;
  int          acc_len = 0, we_cnt = 0, oe_cnt = 0;
  logic [17:0] w_a = '0, r_a = '0;
  logic [15:0] w_d = '0;
  bit          prev_ack = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      acc_len = 0; we_cnt = 0; oe_cnt = 0; prev_ack = 1'b0;
    end else begin
      if (!sram_oe_n) chk("oe_with_dq_driven", {31'd0, dut.dq_oe}, 0);
      if (!sram_we_n) chk("we_without_ce", {31'd0, sram_ce_n}, 0);
      if (prev_ack)
        chk("idle_gap", {26'd0, busy, sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n}, 32'h1F);
      if (!sram_ce_n) acc_len++;
      if (!sram_we_n) begin we_cnt++; w_a = sram_addr; w_d = sram_dq; end
      if (!sram_oe_n) begin oe_cnt++; r_a = sram_addr; end
      if (wr_ack || rd_ack) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ack: got ack with empty scoreboard at %0t", $time);
        end else begin
          me = sb.pop_front();
          chk("ack_kind", {31'd0, rd_ack}, {31'd0, me.rd});
          if (!me.rd) begin
            chk("wr_addr_pin", {14'd0, w_a}, {14'd0, me.a});
            chk("wr_data_pin", {16'd0, w_d}, {16'd0, me.d});
            chk("we_low_cycles", we_cnt, WR_WAIT);
            chk("wr_latency", acc_len, 2 + WR_WAIT);
          end else begin
            chk("rd_addr_pin", {14'd0, r_a}, {14'd0, me.a});
            chk("rd_data", {16'd0, rd_data}, {16'd0, me.d});
            chk("oe_low_cycles", oe_cnt, RD_WAIT);
            chk("rd_latency", acc_len, 1 + RD_WAIT);
          end
        end
        acc_len = 0; we_cnt = 0; oe_cnt = 0;
      end
      prev_ack = wr_ack || rd_ack;
    end
  end

  // stimulus: pending work lists, both requesters held until drained
  logic [17:0] wa[$], ra[$];
  logic [15:0] wd[$];

  task automatic run();
    int nw = wa.size();
    int nr = ra.size();
    int i = 0, j = 0, wi = 0, ri = 0, cyc = 0;
    while (i < nw || j < nr) begin
      if (i < nw && (j >= nr || last_rd)) begin
        sb.push_back('{1'b0, wa[i], wd[i]});
        ref_mem[int'(wa[i])] = wd[i];
        last_rd = 1'b0;
        i++;
      end else begin
        sb.push_back('{1'b1, ra[j], ref_rd(ra[j])});
        last_rd = 1'b1;
        j++;
      end
    end
    if (nw > 0) begin wr_addr = wa[0]; wr_data = wd[0]; wr_req = 1'b1; end
    if (nr > 0) begin rd_addr = ra[0]; rd_req = 1'b1; end
    while ((wi < nw || ri < nr) && cyc < 300) begin
      @(posedge clk); #1; cyc++;
      if (wr_ack) begin
        wi++;
        if (wi < nw) begin wr_addr = wa[wi]; wr_data = wd[wi]; end
        else wr_req = 1'b0;
      end
      if (rd_ack) begin
        ri++;
        if (ri < nr) rd_addr = ra[ri];
        else rd_req = 1'b0;
      end
    end
    if (cyc >= 300) begin
      checks++; errors++;
      $display("FAIL ack_timeout: got %0d/%0d acks expected %0d/%0d", wi, ri, nw, nr);
      wr_req = 1'b0; rd_req = 1'b0;
      sb.delete();
    end
    wa.delete(); wd.delete(); ra.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic reset_mid_write();
    int cyc = 0;
    wr_addr = 18'h2AAAA; wr_data = 16'h1234; wr_req = 1'b1;
    while (sram_we_n && cyc < 20) begin @(negedge clk); cyc++; end
    chk("reach_w_pulse", {31'd0, sram_we_n}, 0);
    #1 reset = 1'b1; wr_req = 1'b0;
    #1;
    chk("rst_strobes", {27'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n}, 32'h1F);
    chk("rst_dq_released", {31'd0, dut.dq_oe}, 0);
    chk("rst_no_wr_ack", {31'd0, wr_ack}, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    last_rd = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy_after", {31'd0, busy}, 0);
    chk("rst_no_ack_after", {30'd0, wr_ack, rd_ack}, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_strobes", {27'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n}, 32'h1F);
    chk("reset_addr", {14'd0, sram_addr}, 0);
    chk("reset_acks_busy", {29'd0, wr_ack, rd_ack, busy}, 0);
    chk("reset_rd_data", {16'd0, rd_data}, 0);
    chk("reset_dq_released", {31'd0, dut.dq_oe}, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    wa.push_back(18'h00010); wd.push_back(16'hA5A5);
    run();
    ra.push_back(18'h00010);
    run();
    wa.push_back(18'h3FFFF); wd.push_back(16'hBEEF);
    run();
    ra.push_back(18'h3FFFF);
    run();

    reset_mid_write();

    // continuous contention, write expected first after reset
    for (int k = 0; k < 4; k++) begin
      wa.push_back(18'(k * 3 + 1));
      wd.push_back(16'(16'hC000 + k));
      ra.push_back(18'(k * 3));
    end
    run();

    for (int r = 0; r < 30; r++) begin
      int nw = $urandom_range(0, 3);
      int nr = $urandom_range(0, 3);
      if (nw + nr == 0) nw = 1;
      for (int k = 0; k < nw; k++) begin
        wa.push_back(($urandom_range(0, 7) == 0) ? 18'h3FFFF : 18'($urandom_range(0, 15)));
        wd.push_back(16'($urandom));
      end
      for (int k = 0; k < nr; k++)
        ra.push_back(($urandom_range(0, 7) == 0) ? 18'h3FFFF : 18'($urandom_range(0, 15)));
      run();
    end

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Arbitrates the single 256K x 16 audio SRAM between two requesters: the ADC capture path (writes) and the DAC playback path (reads).
- Owns every SRAM control pin and the tri-state data bus, and sequences setup, strobe and hold timing for each access.
- Sits between the codec-side sample engines and the board SRAM. Requesters never drive SRAM pins directly.

Parameters:
- ADDR_W, 18, SRAM word address width
- DATA_W, 16, SRAM data width
- WR_WAIT, 1, clk cycles sram_we_n is held low (>=1)
- RD_WAIT, 1, clk cycles from address/oe_n valid to data sample (>=1)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- wr_req  in  1  capture write request; level, held until wr_ack
- wr_addr  in  ADDR_W  write word address; sampled at grant
- wr_data  in  DATA_W  write sample; sampled at grant
- wr_ack  out  1  one-cycle pulse: write complete
- rd_req  in  1  playback read request; level, held until rd_ack
- rd_addr  in  ADDR_W  read word address; sampled at grant
- rd_data  out  DATA_W  read result; valid from rd_ack, held until the next read completes
- rd_ack  out  1  one-cycle pulse: rd_data updated
- busy  out  1  high whenever the FSM is not in IDLE
- sram_addr  out  ADDR_W  SRAM address
- sram_dq  inout  DATA_W  SRAM data bus; driven only during write states, else high-Z
- sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n  out  1 each  SRAM strobes, active-low

Behaviour:
- Reset (async, any state): FSM to IDLE. Outputs take these values:
  - sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n = 1
  - sram_dq = Z, sram_addr = 0
  - wr_ack = 0, rd_ack = 0, rd_data = 0, busy = 0
  - last_grant = READ, so the first contested grant goes to the write side.
- Reset mid-access aborts the access. No ack is issued and the aborted write's memory contents are undefined.
- All SRAM pin outputs are registered. Strobes change only on clk rising edges.
- States: IDLE, W_SETUP, W_PULSE, W_HOLD, R_ADDR, R_SAMPLE.
- IDLE arbitration:
  - Only wr_req: grant write.
  - Only rd_req: grant read.
  - Both: round-robin, granting the side opposite to last_grant.
  - Neither: stay in IDLE.
  - On grant, latch address (and data for a write) and update last_grant.
- Write sequence:
  - W_SETUP (1 cycle): ce_n=0, lb_n=0, ub_n=0, oe_n=1, we_n=1; sram_addr and sram_dq driven.
  - W_PULSE (WR_WAIT cycles): we_n=0.
  - W_HOLD (1 cycle): we_n=1, dq still driven, wr_ack=1.
  - Then IDLE. Total 2+WR_WAIT cycles.
- Read sequence:
  - R_ADDR (RD_WAIT cycles): ce_n=0, oe_n=0, lb_n=0, ub_n=0, dq=Z.
  - R_SAMPLE (1 cycle): capture sram_dq into rd_data, rd_ack=1, oe_n back to 1.
  - Then IDLE. Total 1+RD_WAIT cycles.
- Every access returns through IDLE for at least 1 cycle with all strobes high. This guarantees bus turnaround: sram_oe_n low and sram_dq driven are never simultaneous.
- Wait counter is sized ceil(log2(max(WR_WAIT,RD_WAIT)+1)), loaded on state entry and decremented to 0. It never wraps.
- A requester that keeps its req high after its ack is re-arbitrated in the next IDLE cycle. Under continuous contention the sides alternate W,R,W,R.
- A req dropped before its grant is ignored. A req dropped after grant does not cancel the access.
- Address and data changes after grant have no effect on the current access.
- No address bound checking. 18'h3FFFF is a legal address; end-of-memory stop is the requester's job.

Decomposition:
- Shared package sram_pkg holds:
  - ADDR_W and DATA_W constants
  - state enum type sram_state_t
  - grant enum (WRITE/READ) used by last_grant
- No sub-module. Arbitration, FSM and pin registers stay in one module. The tri-state is a single continuous assignment gated by an internal dq_oe register.

Test Plan:
- Reset asserted mid-W_PULSE -> same cycle all strobes = 1, sram_dq = Z, no wr_ack; after release busy = 0.
- Single write addr=18'h00010, data=16'hA5A5, WR_WAIT=1 -> we_n low exactly 1 cycle with dq=A5A5, addr=00010. wr_ack pulses 3 cycles after grant.
- Single read addr=18'h00010, SRAM model returns 16'hA5A5, RD_WAIT=2 -> oe_n low 2 cycles, rd_data=A5A5 with rd_ack on cycle 3.
- wr_req and rd_req both held high for 8 accesses -> grants alternate W,R,W,R..., with write first after reset. Each access is separated by an IDLE cycle with all strobes high.
- Addr 18'h3FFFF write then read -> data round-trips; no wrap or refusal.
- Bus-contention checker over random traffic -> never sram_oe_n=0 while dq driven; sram_we_n=0 only while ce_n=0.
